pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Fetch-stage program-counter sequencer. Holds the PC and drives the operands of the
//  32-bit ripple adder (full_adder_32) instantiated beside it in the CPU top. The adder
//  is fed with PC plus an increment or a branch offset; the sum returns as the next PC.
//  Handles stalls, PC-relative branches, absolute jumps and post-redirect flush bubbles.
// PARAMETERS
//  WIDTH        32  PC/address width; adder operand width
//  RESET_PC     0   PC value loaded by reset
//  INC          1   sequential increment (word-addressed instruction memory)
//  FLUSH_CYCLES 1   bubble cycles after a redirect; legal range 1..7
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      asynchronous, active-high reset
//  stall          in   1      hold PC (hazard or memory wait)
//  branch         in   1      take PC-relative branch this cycle
//  branch_offset  in   WIDTH  two's-complement offset added to current PC
//  jump           in   1      take absolute jump this cycle
//  jump_target    in   WIDTH  absolute jump destination
//  add_a          out  WIDTH  adder operand A (= pc)
//  add_b          out  WIDTH  adder operand B
//  add_s          in   WIDTH  adder sum (combinational return path)
//  pc             out  WIDTH  current fetch address
//  pc_valid       out  1      pc is a real fetch (0 = bubble)
//  flush          out  1      squash younger pipeline stages
//  fetch_count    out  WIDTH  count of sequential advances; wraps
// BEHAVIOUR
//  - Reset: all outputs cleared asynchronously: pc=RESET_PC, pc_valid=0, flush=0,
//    fetch_count=0, state=IDLE.
//  - add_a = pc always. add_b = branch_offset when (state==RUN && branch && !jump),
//    else INC. Both are combinational.
//  - FSM:
//    IDLE : pc_valid=0. Goes to RUN after one cycle unconditionally; inputs ignored.
//    RUN  : pc_valid=1. Priority per cycle is jump > branch > stall > advance.
//           jump   -> pc<=jump_target; load flush counter; go to FLUSH.
//           branch -> pc<=add_s (pc+offset); load flush counter; go to FLUSH.
//           stall  -> pc held; fetch_count held.
//           else   -> pc<=add_s (pc+INC); fetch_count++.
//    FLUSH: pc_valid=0, flush=1. pc held. stall, branch and jump ignored
//           (they come from squashed instructions). Stays FLUSH_CYCLES cycles, then RUN.
//  - The redirect takes effect on the next edge. The new pc appears with pc_valid=0,
//    and pc_valid returns exactly FLUSH_CYCLES cycles later.
//  - Arithmetic is mod 2^WIDTH. Adder carry-out does not exist and is not needed;
//    0xFFFFFFFF+1 wraps to 0. fetch_count also wraps silently.
//  - Negative offsets are plain two's complement; no sign-extension happens in this block.
//  - Reset asserted mid-FLUSH or mid-stall: immediate return to reset values;
//    no pending redirect survives.
// STRUCTURE
//  - Shared package/header (cpu_defs): PC_WIDTH, RESET_VECTOR, PC_INC.
//  - Local to this block: state encodings IDLE/RUN/FLUSH (2-bit) and the 3-bit flush counter.
//  - No sub-module. The adder stays outside and is wired by the parent, so the ripple
//    path is add_a -> add_s -> pc D-input. Timing is closed at the top.
// TESTING
//  1. Reset release, RESET_PC=0, no stall: one cycle pc=0/pc_valid=0, then
//     pc=0,1,2,3 with pc_valid=1; fetch_count counts 1,2,3.
//  2. stall high 3 cycles at pc=5: pc stays 5 and fetch_count is frozen.
//     On release pc=6 next cycle.
//  3. branch with offset 0xFFFFFFFC at pc=10: next pc=6 with flush=1 and pc_valid=0
//     for 1 cycle. Then pc_valid=1 at pc=6 and pc=7 follows.
//  4. jump and branch together, jump_target=0x100: pc=0x100 (jump wins). A branch
//     asserted during FLUSH is ignored; pc resumes 0x101.
//  5. RESET_PC=0xFFFFFFFE: sequence is 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
//  6. rst pulsed asynchronously mid-FLUSH (FLUSH_CYCLES=3): outputs go to reset values
//     before the next edge. Then the IDLE -> RUN sequence repeats from RESET_PC.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared fetch-stage definitions: default PC geometry and the sequencer state encoding.
package pc_sequencer_pkg;

   localparam int          PC_WIDTH     = 32;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] PC_INC       = 32'h0000_0001;

   // IDLE: first cycle out of reset, RUN: fetching, FLUSH: post-redirect bubbles
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: drives an external adder with PC plus increment/offset and
// registers the returned sum; handles stall, branch, jump and flush bubbles.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int               WIDTH        = PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_PC     = WIDTH'(RESET_VECTOR),
   parameter logic [WIDTH-1:0] INC          = WIDTH'(PC_INC),
   parameter int               FLUSH_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             branch,
   input  logic [WIDTH-1:0] branch_offset,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH-1:0] add_s,
   output logic [WIDTH-1:0] pc,
   output logic             pc_valid,
   output logic             flush,
   output logic [WIDTH-1:0] fetch_count,
   output pc_state_e        state
);

   // Counter holds remaining FLUSH cycles minus one, so RUN resumes exactly FLUSH_CYCLES later
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   pc_state_e        state_q;
   logic [WIDTH-1:0] pc_q;
   logic             pc_valid_q;
   logic             flush_q;
   logic [WIDTH-1:0] fetch_count_q;
   logic [2:0]       flush_cnt_q;

   assign add_a       = pc_q;
   assign add_b       = (state_q == ST_RUN && branch && !jump) ? branch_offset : INC;
   assign pc          = pc_q;
   assign pc_valid    = pc_valid_q;
   assign flush       = flush_q;
   assign fetch_count = fetch_count_q;
   assign state       = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         pc_valid_q    <= 1'b0;
         flush_q       <= 1'b0;
         fetch_count_q <= '0;
         flush_cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q    <= ST_RUN;
               pc_valid_q <= 1'b1;
            end
            ST_RUN: begin
               if (jump || branch) begin
                  // add_b already carries the branch offset here, so add_s is pc+offset
                  pc_q        <= jump ? jump_target : add_s;
                  state_q     <= ST_FLUSH;
                  pc_valid_q  <= 1'b0;
                  flush_q     <= 1'b1;
                  flush_cnt_q <= FLUSH_LOAD;
               end else if (!stall) begin
                  pc_q          <= add_s;
                  fetch_count_q <= fetch_count_q + WIDTH'(1);
               end
            end
            ST_FLUSH: begin
               if (flush_cnt_q == 3'd0) begin
                  state_q    <= ST_RUN;
                  pc_valid_q <= 1'b1;
                  flush_q    <= 1'b0;
               end else begin
                  flush_cnt_q <= flush_cnt_q - 3'd1;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               pc_valid_q <= 1'b0;
               flush_q    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: three instances (default, wrap-around reset PC, 3-cycle flush),
// each closed through a behavioural adder.
module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

   // Handshake-free block: inputs are sampled on the rising edge, outputs checked on the falling edge.

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic        z1  = 1'b0;
   logic [31:0] z32 = 32'h0;

   // instance A: default parameters
   logic        rst_a, stall_a, branch_a, jump_a;
   logic [31:0] off_a, tgt_a, a_a, b_a, s_a, pc_a, fc_a;
   logic        v_a, fl_a;
   pc_state_e   st_a;
   assign s_a = a_a + b_a;

   pc_sequencer u_dut (
      .clk(clk), .rst(rst_a), .stall(stall_a), .branch(branch_a), .branch_offset(off_a),
      .jump(jump_a), .jump_target(tgt_a), .add_a(a_a), .add_b(b_a), .add_s(s_a),
      .pc(pc_a), .pc_valid(v_a), .flush(fl_a), .fetch_count(fc_a), .state(st_a)
   );

   // instance W: reset PC near the top of the address space
   logic        rst_w;
   logic [31:0] a_w, b_w, s_w, pc_w, fc_w;
   logic        v_w, fl_w;
   pc_state_e   st_w;
   assign s_w = a_w + b_w;

   pc_sequencer #(.RESET_PC(32'hFFFF_FFFE)) u_wrap (
      .clk(clk), .rst(rst_w), .stall(z1), .branch(z1), .branch_offset(z32),
      .jump(z1), .jump_target(z32), .add_a(a_w), .add_b(b_w), .add_s(s_w),
      .pc(pc_w), .pc_valid(v_w), .flush(fl_w), .fetch_count(fc_w), .state(st_w)
   );

   // instance F: three flush cycles
   logic        rst_f, branch_f, jump_f;
   logic [31:0] off_f, tgt_f, a_f, b_f, s_f, pc_f, fc_f;
   logic        v_f, fl_f;
   pc_state_e   st_f;
   assign s_f = a_f + b_f;

   pc_sequencer #(.FLUSH_CYCLES(3)) u_fl3 (
      .clk(clk), .rst(rst_f), .stall(z1), .branch(branch_f), .branch_offset(off_f),
      .jump(jump_f), .jump_target(tgt_f), .add_a(a_f), .add_b(b_f), .add_s(s_f),
      .pc(pc_f), .pc_valid(v_f), .flush(fl_f), .fetch_count(fc_f), .state(st_f)
   );

   // ---------------- scoreboard ----------------
   logic [65:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        st;
      logic        br;
      logic [31:0] off;
      logic        jp;
      logic [31:0] tgt;
      logic [31:0] b;
      logic [31:0] pc;
      logic        v;
      logic        fl;
      logic [31:0] fc;
   } vec_t;

   function automatic vec_t mk(input logic st, input logic br, input logic [31:0] off,
                               input logic jp, input logic [31:0] tgt, input logic [31:0] b,
                               input logic [31:0] pc, input logic v, input logic fl,
                               input logic [31:0] fc);
      vec_t r;
      r.st = st; r.br = br; r.off = off; r.jp = jp; r.tgt = tgt;
      r.b = b; r.pc = pc; r.v = v; r.fl = fl; r.fc = fc;
      return r;
   endfunction

   logic [31:0] cur_pc = 32'h0;

   // ---------------- driver ----------------
   task automatic apply(input vec_t v, input int idx);
      logic [65:0] e;
      stall_a  = v.st;
      branch_a = v.br;
      off_a    = v.off;
      jump_a   = v.jp;
      tgt_a    = v.tgt;
      #1;
      chk($sformatf("row%0d add_a", idx), a_a, cur_pc);
      chk($sformatf("row%0d add_b", idx), b_a, v.b);
      exp_q.push_back({v.pc, v.v, v.fl, v.fc});
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("row%0d pc", idx), pc_a, e[65:34]);
      chk($sformatf("row%0d pc_valid", idx), {31'h0, v_a}, {31'h0, e[33]});
      chk($sformatf("row%0d flush", idx), {31'h0, fl_a}, {31'h0, e[32]});
      chk($sformatf("row%0d fetch_count", idx), fc_a, e[31:0]);
      cur_pc = e[65:34];
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   vec_t        tbl[22];
   logic [31:0] wexp[4];

   initial begin
      rst_a = 1'b1; rst_w = 1'b1; rst_f = 1'b1;
      stall_a = 1'b0; branch_a = 1'b0; jump_a = 1'b0; off_a = '0; tgt_a = '0;
      branch_f = 1'b0; jump_f = 1'b0; off_f = '0; tgt_f = '0;

      //         st br off           jp tgt        add_b         pc            v  fl fc
      tbl[0]  = mk(0, 1, 32'h50,       0, 32'h0,   32'h1,        32'h0,        1, 0, 32'd0);
      tbl[1]  = mk(0, 0, 32'h0,        0, 32'h0,   32'h1,        32'h1,        1, 0, 32'd1);
      tbl[2]  = mk(0, 0, 32'h0,        0, 32'h0,   32'h1,        32'h2,        1, 0, 32'd2);
      tbl[3]  = mk(0, 0, 32'h0,        0, 32'h0,   32'h1,        32'h3,        1, 0, 32'd3);
      tbl[4]  = mk(0, 0, 32'h0,        0, 32'h0,   32'h1,        32'h4,        1, 0, 32'd4);
      tbl[5]  = mk(0, 0, 32'h0,        0, 32'h0,   32'h1,        32'h5,        1, 0, 32'd5);
      tbl[6]  = mk(1, 0, 32'h0,        0, 32'h0,   32'h1,        32'h5,        1, 0, 32'd5);
      tbl[7]  = mk(1, 0, 32'h0,        0, 32'h0,   32'h1,        32'h5,        1, 0, 32'd5);
      tbl[8]  = mk(1, 0, 32'h0,        0, 32'h0,   32'h1,        32'h5,        1, 0, 32'd5);
      tbl[9]  = mk(0, 0, 32'h0,        0, 32'h0,   32'h1,        32'h6,        1, 0, 32'd6);
      tbl[10] = mk(0, 0, 32'h0,        0, 32'h0,   32'h1,        32'h7,        1, 0, 32'd7);
      tbl[11] = mk(0, 0, 32'h0,        0, 32'h0,   32'h1,        32'h8,        1, 0, 32'd8);
      tbl[12] = mk(0, 0, 32'h0,        0, 32'h0,   32'h1,        32'h9,        1, 0, 32'd9);
      tbl[13] = mk(0, 0, 32'h0,        0, 32'h0,   32'h1,        32'hA,        1, 0, 32'd10);
      tbl[14] = mk(0, 1, 32'hFFFF_FFFC, 0, 32'h0,  32'hFFFF_FFFC, 32'h6,       0, 1, 32'd10);
      tbl[15] = mk(1, 1, 32'h33,       0, 32'h0,   32'h1,        32'h6,        1, 0, 32'd10);
      tbl[16] = mk(0, 0, 32'h0,        0, 32'h0,   32'h1,        32'h7,        1, 0, 32'd11);
      tbl[17] = mk(0, 1, 32'h5,        1, 32'h100, 32'h1,        32'h100,      0, 1, 32'd11);
      tbl[18] = mk(0, 1, 32'h40,       0, 32'h0,   32'h1,        32'h100,      1, 0, 32'd11);
      tbl[19] = mk(0, 0, 32'h0,        0, 32'h0,   32'h1,        32'h101,      1, 0, 32'd12);
      tbl[20] = mk(1, 1, 32'h10,       0, 32'h0,   32'h10,       32'h111,      0, 1, 32'd12);
      tbl[21] = mk(0, 0, 32'h0,        0, 32'h0,   32'h1,        32'h111,      1, 0, 32'd12);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset pc", pc_a, 32'h0);
      chk("reset pc_valid", {31'h0, v_a}, 32'h0);
      chk("reset flush", {31'h0, fl_a}, 32'h0);
      chk("reset fetch_count", fc_a, 32'h0);
      chk("reset state", 32'(st_a), 32'(ST_IDLE));
      rst_a = 1'b0;

      for (int i = 0; i < 22; i++) apply(tbl[i], i);
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

      // wrap-around from a high reset PC
      wexp[0] = 32'hFFFF_FFFE; wexp[1] = 32'hFFFF_FFFF; wexp[2] = 32'h0; wexp[3] = 32'h1;
      chk("wrap reset pc", pc_w, 32'hFFFF_FFFE);
      chk("wrap reset pc_valid", {31'h0, v_w}, 32'h0);
      rst_w = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("wrap pc%0d", i), pc_w, wexp[i]);
         chk($sformatf("wrap pc_valid%0d", i), {31'h0, v_w}, 32'h1);
      end
      chk("wrap fetch_count", fc_w, 32'd3);

      // three-cycle flush, then asynchronous reset in the middle of a flush
      rst_f = 1'b0;
      tick();
      chk("f3 run pc", pc_f, 32'h0);
      chk("f3 run pc_valid", {31'h0, v_f}, 32'h1);
      jump_f = 1'b1; tgt_f = 32'h20;
      tick();
      jump_f = 1'b0; branch_f = 1'b1; off_f = 32'h4;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("f3 bubble%0d pc", i), pc_f, 32'h20);
         chk($sformatf("f3 bubble%0d pc_valid", i), {31'h0, v_f}, 32'h0);
         chk($sformatf("f3 bubble%0d flush", i), {31'h0, fl_f}, 32'h1);
         tick();
      end
      branch_f = 1'b0;
      chk("f3 resume pc", pc_f, 32'h20);
      chk("f3 resume pc_valid", {31'h0, v_f}, 32'h1);
      chk("f3 resume flush", {31'h0, fl_f}, 32'h0);
      tick();
      chk("f3 advance pc", pc_f, 32'h21);
      chk("f3 advance fetch_count", fc_f, 32'd1);
      jump_f = 1'b1; tgt_f = 32'h40;
      tick();
      jump_f = 1'b0;
      chk("f3 redirect pc", pc_f, 32'h40);
      chk("f3 redirect flush", {31'h0, fl_f}, 32'h1);
      #2 rst_f = 1'b1;
      #1;
      chk("f3 async pc", pc_f, 32'h0);
      chk("f3 async pc_valid", {31'h0, v_f}, 32'h0);
      chk("f3 async flush", {31'h0, fl_f}, 32'h0);
      chk("f3 async fetch_count", fc_f, 32'h0);
      chk("f3 async state", 32'(st_f), 32'(ST_IDLE));
      @(negedge clk);
      rst_f = 1'b0;
      chk("f3 idle pc_valid", {31'h0, v_f}, 32'h0);
      tick();
      chk("f3 rerun pc", pc_f, 32'h0);
      chk("f3 rerun pc_valid", {31'h0, v_f}, 32'h1);
      chk("f3 rerun flush", {31'h0, fl_f}, 32'h0);
      tick();
      chk("f3 rerun pc1", pc_f, 32'h1);
      chk("f3 rerun fetch_count", fc_f, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
